// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory stage doing byte/half/word accesses over a req/gnt/rvalid bus
module load_store_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter bit MISALIGN_CHECK = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           StoreData,
  input  logic [4:0]            Rd,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [4:0]            wb_rd,
  output logic [31:0]           wb_data,
  output logic                  misaligned
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;
  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            f3_q;
  logic [4:0]            rd_q;
  logic [31:0]           sd_q;
  logic                  we_q;
  logic                  in_h, in_w, in_mis, accept;
  logic [1:0]            in_lo;
  logic                  q_h, q_w;
  logic [1:0]            o;
  logic [31:0]           sh_b, sh_h, ld_val;
  assign accept   = ex_valid & (MemRead | MemWrite);
  assign in_w     = Funct3[1];
  assign in_h     = ~Funct3[1] & Funct3[0];
  assign in_mis   = (in_h & Address[0]) | (in_w & (Address[1:0] != 2'b00));
  assign in_lo    = in_w ? 2'b00 : in_h ? {Address[1], 1'b0} : Address[1:0];
  assign q_w      = f3_q[1];
  assign q_h      = ~f3_q[1] & f3_q[0];
  assign o        = addr_q[1:0];
  assign sh_b     = mem_rdata >> {o, 3'b000};
  assign sh_h     = mem_rdata >> {o[1], 4'b0000};
  assign ld_val   = q_w ? mem_rdata
                  : q_h ? {{16{~f3_q[2] & sh_h[15]}}, sh_h[15:0]}
                  : {{24{~f3_q[2] & sh_b[7]}}, sh_b[7:0]};
  assign ex_ready   = state == IDLE;
  assign mem_req    = state == REQ;
  assign mem_we     = mem_req & we_q;
  assign mem_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wdata  = q_w ? sd_q : q_h ? {2{sd_q[15:0]}} : {4{sd_q[7:0]}};
  assign mem_wstrb  = ~mem_we ? 4'b0000 : q_w ? 4'b1111 : q_h ? 4'b0011 << o : 4'b0001 << o;
  assign wb_valid   = state == DONE;
  assign wb_we      = wb_valid & ~we_q;
  assign wb_rd      = rd_q;
  assign misaligned = state == ERR;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      sd_q    <= '0;
      we_q    <= 1'b0;
      wb_data <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          addr_q <= MISALIGN_CHECK ? Address : {Address[ADDR_WIDTH-1:2], in_lo};
          f3_q   <= Funct3;
          rd_q   <= Rd;
          sd_q   <= StoreData;
          we_q   <= MemWrite;
          state  <= (MISALIGN_CHECK && in_mis) ? ERR : REQ;
        end
        REQ:  if (mem_gnt) state <= we_q ? DONE : WAIT;
        WAIT: if (mem_rvalid) begin
          wb_data <= ld_val;
          state   <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit
module tb_load_store_unit;
  logic        clk, rst_n, ex_valid, ex_ready, MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Address, StoreData, mem_addr, mem_wdata, mem_rdata, wb_data;
  logic [4:0]  Rd, wb_rd;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, wb_valid, wb_we, misaligned;
  logic [3:0]  mem_wstrb;
  int          total = 0;
  int          bad = 0;
  load_store_unit #(.ADDR_WIDTH(32), .MISALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3), .Address(Address),
    .StoreData(StoreData), .Rd(Rd), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .misaligned(misaligned)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r);
    ex_valid = 1'b1; MemRead = rd_en; MemWrite = wr_en; Funct3 = f3;
    Address = a; StoreData = sd; Rd = r;
    step();
    ex_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
  endtask
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rdata, input logic [4:0] r, input logic [31:0] exp);
    issue(1'b1, 1'b0, f3, a, 32'h0, r);
    chk({tag, "_req"}, mem_req, 1);
    chk({tag, "_we"}, mem_we, 0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk({tag, "_wait_req"}, mem_req, 0);
    mem_rvalid = 1'b1; mem_rdata = rdata;
    step();
    mem_rvalid = 1'b0; mem_rdata = 32'hDEADBEEF;
    chk({tag, "_wbv"}, wb_valid, 1);
    chk({tag, "_wbwe"}, wb_we, 1);
    chk({tag, "_wbrd"}, wb_rd, r);
    chk({tag, "_data"}, wb_data, exp);
    step();
    chk({tag, "_wbv_off"}, wb_valid, 0);
    chk({tag, "_ready"}, ex_ready, 1);
  endtask
  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'd0;
    Address = 32'h0; StoreData = 32'h0; Rd = 5'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    step(); step();
    chk("rst_ready", ex_ready, 1);
    chk("rst_req", mem_req, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_mis", misaligned, 0);
    chk("rst_wstrb", mem_wstrb, 0);
    rst_n = 1'b1;
    step();
    ex_valid = 1'b1;
    step();
    ex_valid = 1'b0;
    chk("noop_ready", ex_ready, 1);
    chk("noop_req", mem_req, 0);
    issue(1'b0, 1'b1, 3'b000, 32'h00000103, 32'h000000A5, 5'd3);
    chk("sb_req", mem_req, 1);
    chk("sb_ready", ex_ready, 0);
    chk("sb_we", mem_we, 1);
    chk("sb_addr", mem_addr, 32'h00000100);
    chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    chk("sb_wstrb", mem_wstrb, 4'b1000);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("sb_wbv", wb_valid, 1);
    chk("sb_wbwe", wb_we, 0);
    chk("sb_req_off", mem_req, 0);
    step();
    chk("sb_wbv_off", wb_valid, 0);
    chk("sb_ready2", ex_ready, 1);
    do_load("lb", 3'b000, 32'h00000202, 32'h12F05678, 5'd7, 32'hFFFFFFF0);
    do_load("lbu", 3'b100, 32'h00000202, 32'h12F05678, 5'd7, 32'h000000F0);
    do_load("lh", 3'b001, 32'h00000006, 32'h80017FFF, 5'd9, 32'hFFFF8001);
    do_load("lhu", 3'b101, 32'h00000006, 32'h80017FFF, 5'd9, 32'h00008001);
    do_load("lb0", 3'b000, 32'h00000300, 32'h12F05678, 5'd1, 32'h00000078);
    do_load("lhlo", 3'b001, 32'h00000300, 32'h1234ABCD, 5'd2, 32'hFFFFABCD);
    do_load("lf3_6", 3'b110, 32'h00000304, 32'hCAFEF00D, 5'd4, 32'hCAFEF00D);
    issue(1'b0, 1'b1, 3'b001, 32'h00000012, 32'h0000BEEF, 5'd0);
    chk("sh_wdata", mem_wdata, 32'hBEEFBEEF);
    chk("sh_wstrb", mem_wstrb, 4'b1100);
    mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
    chk("sh_wbv", wb_valid, 1);
    chk("sh_hold", wb_data, 32'hCAFEF00D);
    step();
    issue(1'b1, 1'b1, 3'b010, 32'h00000020, 32'h01234567, 5'd5);
    chk("sw_both_we", mem_we, 1);
    chk("sw_wdata", mem_wdata, 32'h01234567);
    chk("sw_wstrb", mem_wstrb, 4'b1111);
    mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
    chk("sw_both_wbwe", wb_we, 0);
    step();
    issue(1'b1, 1'b0, 3'b010, 32'h00000440, 32'h0, 5'd11);
    for (int i = 0; i < 3; i++) begin
      chk("lw_stall_req", mem_req, 1);
      chk("lw_stall_addr", mem_addr, 32'h00000440);
      chk("lw_stall_ready", ex_ready, 0);
      step();
    end
    chk("lw_gnt_req", mem_req, 1);
    mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
    chk("lw_wait1_req", mem_req, 0);
    chk("lw_wait1_ready", ex_ready, 0);
    chk("lw_wait1_wbv", wb_valid, 0);
    step();
    chk("lw_wait2_ready", ex_ready, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h89ABCDEF;
    step();
    mem_rvalid = 1'b0;
    chk("lw_wbv", wb_valid, 1);
    chk("lw_rd", wb_rd, 5'd11);
    chk("lw_data", wb_data, 32'h89ABCDEF);
    step();
    issue(1'b0, 1'b1, 3'b010, 32'h00000002, 32'h11111111, 5'd0);
    chk("mis_pulse", misaligned, 1);
    chk("mis_req", mem_req, 0);
    chk("mis_wbv", wb_valid, 0);
    step();
    chk("mis_off", misaligned, 0);
    chk("mis_ready", ex_ready, 1);
    chk("mis_req2", mem_req, 0);
    chk("mis_hold", wb_data, 32'h89ABCDEF);
    issue(1'b1, 1'b0, 3'b001, 32'h00000005, 32'h0, 5'd0);
    chk("mish_pulse", misaligned, 1);
    step();
    issue(1'b1, 1'b0, 3'b010, 32'h00000500, 32'h0, 5'd12);
    chk("arst_pre_req", mem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", mem_req, 0);
    chk("arst_ready", ex_ready, 1);
    chk("arst_wbv", wb_valid, 0);
    step();
    rst_n = 1'b1;
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("arst_no_wbv", wb_valid, 0);
      chk("arst_idle_req", mem_req, 0);
      step();
    end
    mem_rvalid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
